// File: rtl/keypad_code_accumulator_if.sv
// Keypad accumulator bus: key strobes in, submitted code and entry status out.
// The master side (key decoder / bench) drives keys; the accumulator is the slave.
interface keypad_code_accumulator_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [31:0] code;
    logic        code_ready;
    logic        entering;
    logic [3:0]  digit_count;
    logic        overflow;
    logic        timeout;

    modport master (
        output key_valid,
        output key_code,
        input  code,
        input  code_ready,
        input  entering,
        input  digit_count,
        input  overflow,
        input  timeout
    );

    modport slave (
        input  key_valid,
        input  key_code,
        output code,
        output code_ready,
        output entering,
        output digit_count,
        output overflow,
        output timeout
    );
endinterface

// File: rtl/keypad_code_accumulator.sv
// Accumulates decimal key strobes into a 32-bit code word, with clear, enter
// and an inactivity timeout that discards stale entries.
module keypad_code_accumulator #(
    parameter int MAX_DIGITS     = 7,
    parameter int TIMEOUT_CYCLES = 60000000,
    parameter int TO_W           = 26
) (
    input  logic                        hwclk,
    input  logic                        rst_n,
    keypad_code_accumulator_if.slave    kp
);

    localparam logic [3:0]      MAX_CNT = 4'(MAX_DIGITS);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        IDLE,
        ENTRY
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       acc_q, acc_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [31:0]       code_q, code_d;
    logic              code_ready_q, code_ready_d;
    logic              timeout_q, timeout_d;

    logic              is_digit;
    logic              is_clear;
    logic              is_enter;

    // Codes 0xC-0xF decode to nothing, so they behave exactly like an idle cycle.
    assign is_digit = kp.key_valid && (kp.key_code <= 4'd9);
    assign is_clear = kp.key_valid && (kp.key_code == 4'hA);
    assign is_enter = kp.key_valid && (kp.key_code == 4'hB);

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            to_cnt_q     <= '0;
            code_q       <= '0;
            code_ready_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            to_cnt_q     <= to_cnt_d;
            code_q       <= code_d;
            code_ready_q <= code_ready_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        to_cnt_d     = to_cnt_q;
        code_d       = code_q;
        code_ready_d = 1'b0;
        timeout_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                to_cnt_d = '0;
                if (is_digit) begin
                    acc_d   = {28'd0, kp.key_code};
                    cnt_d   = 4'd1;
                    state_d = ENTRY;
                end
            end

            ENTRY: begin
                // Key events take priority over an expiring timer.
                if (is_digit) begin
                    to_cnt_d = '0;
                    if (cnt_q < MAX_CNT) begin
                        acc_d = (acc_q << 3) + (acc_q << 1) + {28'd0, kp.key_code};
                        cnt_d = cnt_q + 4'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (is_clear || is_enter || (to_cnt_q == TO_LAST)) begin
                    if (is_enter) begin
                        code_d       = ovf_q ? 32'hFFFF_FFFF : acc_q;
                        code_ready_d = 1'b1;
                    end else if (!is_clear) begin
                        timeout_d = 1'b1;
                    end
                    acc_d    = '0;
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                    to_cnt_d = '0;
                    state_d  = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign kp.code        = code_q;
    assign kp.code_ready  = code_ready_q;
    assign kp.entering    = (state_q == ENTRY);
    assign kp.digit_count = cnt_q;
    assign kp.overflow    = ovf_q;
    assign kp.timeout     = timeout_q;

endmodule

// File: doc/keypad_code_accumulator.md
# keypad_code_accumulator

Converts a stream of decoded keypad key strobes into a 32-bit binary code word for the code comparator stage. Decimal digits are accumulated most-significant first (value × 10 + digit). Special keys clear or submit the entry, and idle entries are discarded by an inactivity timeout. On submit, `code` is the comparator's `in` operand and stays stable until the next submit; `code_ready` marks the submit cycle.

## Interface
Parameters:
- `MAX_DIGITS`, default 7: maximum accepted digits per entry; legal range 1..9, so the accumulator can never exceed 32 bits.
- `TIMEOUT_CYCLES`, default 60000000: idle cycles in ENTRY before the entry is discarded (5 s at 12 MHz).
- `TO_W`, default 26: timeout counter width; must satisfy 2^TO_W ≥ TIMEOUT_CYCLES.

Ports:
- `hwclk` in 1: the single system clock (12 MHz).
- `rst_n` in 1: reset, asynchronous, active-low.
- `key_valid` in 1: one-cycle strobe, key event present.
- `key_code` in 4: 0x0–0x9 digit; 0xA clear (*); 0xB enter (#); 0xC–0xF ignored.
- `code` out 32: last submitted code, registered, feeds comparator `in`.
- `code_ready` out 1: one-cycle pulse, coincident with the cycle `code` takes a new value.
- `entering` out 1: high while in ENTRY.
- `digit_count` out 4: digits accepted in the current entry.
- `overflow` out 1: sticky; set when a digit beyond MAX_DIGITS is keyed in the current entry.
- `timeout` out 1: one-cycle pulse when an entry is discarded by timeout.

## Operation
- Internal state: `acc`[31:0], `digit_count`, timeout counter `to_cnt`[TO_W-1:0], and FSM {IDLE, ENTRY}.
- A key event is `key_valid`=1 at a rising `hwclk` edge. Codes 0xC–0xF are fully ignored: no state change and no timer restart.
- IDLE:
  - Digit d: `acc`←d, `digit_count`←1, `to_cnt`←0, go to ENTRY.
  - Clear: no effect.
  - Enter: ignored; empty submits are never produced.
- ENTRY:
  - Digit d with `digit_count` < MAX_DIGITS: `acc`←(acc<<3)+(acc<<1)+d, `digit_count`+1, `to_cnt`←0.
  - Digit d with `digit_count` = MAX_DIGITS: digit dropped, `overflow`←1, `to_cnt`←0.
  - Clear: `acc`←0, `digit_count`←0, `overflow`←0, go to IDLE.
  - Enter: `code`←`acc` (or 0xFFFF_FFFF if `overflow`=1, a value the comparator's range check rejects), `code_ready`←1. Then `acc`, `digit_count` and `overflow` clear, go to IDLE.
  - No key event and `to_cnt` = TIMEOUT_CYCLES-1: `timeout`←1, `acc`, `digit_count` and `overflow` clear, go to IDLE. `code` is unchanged.
  - Otherwise `to_cnt`+1. `to_cnt` is held at 0 in IDLE.
- Simultaneous key event and timeout expiry: the key event wins and no timeout fires.
- `code` changes only on submit; it holds across clear, timeout and new entry.
- All arithmetic is unsigned 32-bit. With MAX_DIGITS ≤ 9 the maximum is 999,999,999, so no wrap occurs.

## Timing
- Reset values: `code`=0, `code_ready`=0, `entering`=0, `digit_count`=0, `overflow`=0, `timeout`=0, `acc`=0, `to_cnt`=0, FSM=IDLE.
- Assertion of `rst_n` mid-entry immediately aborts the entry; no `code_ready` is produced.
- All outputs are registered. A key event sampled at edge N is reflected in outputs after edge N.
- Submit latency: enter at edge N → `code` updated and `code_ready`=1 for cycle N..N+1 only. The comparator registers `match` at edge N+1.
- Back-to-back key events on consecutive cycles are each accepted; no minimum spacing.
- Timeout fires exactly TIMEOUT_CYCLES edges after the last accepted key event with no intervening key event.
- `entering` equals (FSM == ENTRY).

## Test plan
- Reset: hold `rst_n`=0, toggle clock, strobe keys → all outputs 0. Release → IDLE; an enter strobe produces no `code_ready`.
- Keys 1,2,3,4,5,# on consecutive cycles → `digit_count` steps 1..5; `code`=12345 (0x0000_3039); `code_ready` high exactly one cycle after the # edge; `digit_count` returns to 0.
- MAX_DIGITS=7, keys 1..8 then # → `overflow`=1 after the 8th digit, `digit_count`=7, `code`=0xFFFF_FFFF; `overflow` cleared after submit.
- Keys 9,9,*,4,2,# → `code`=42; a 0xD strobe interleaved mid-entry changes nothing.
- TIMEOUT_CYCLES=16: key 7, then idle → `timeout` pulses on the 16th edge and `entering` drops; a following # produces no `code_ready` and `code` keeps its prior value. A key at the expiry edge suppresses the timeout.
- `rst_n` asserted asynchronously mid-entry (between edges, after keys 3,1) → outputs 0 immediately; the subsequent sequence 5,# gives `code`=5.
